idex_bypass_stage: RTL and testbench

- ID/EX pipeline stage sitting directly downstream of the register file in the LEGv8 pipelined datapath.
- Captures the register file read data (rd1/rd2), immediate and control bits each cycle, and presents them to the EX stage.
- Corrects same-cycle write-back hazards: the register file writes on the clock edge, so a read in the same cycle returns the stale value. The block detects this and substitutes the write-back data.
- Detects load-use hazards, inserts a one-cycle bubble and raises a stall request to IF/ID.

---
 rtl/idex_bypass_stage.sv | 163 ++++++++++++++++
 tb/tb_idex_bypass_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_bypass_stage.sv
// idex_bypass_stage: LEGv8 ID/EX pipeline register with write-back bypass
// and load-use hazard detection.
// Optional build macro IDEX_STALL_CNT_EN adds the stall_count output port.

// Per-operand bypass mux: the register file returns stale data when it is
// written on the same edge, so substitute the write-back value.
module idex_bypass_mux #(
  parameter int N  = 64,
  parameter int ZR = 31
) (
  input  logic [4:0]   ra,
  input  logic [N-1:0] rd,
  input  logic         wb_we,
  input  logic [4:0]   wb_wa,
  input  logic [N-1:0] wb_wd,
  output logic [N-1:0] op
);
  localparam logic [4:0] ZR_IDX = 5'(ZR);

  // XZR is never bypassed; the register file already returns 0 for it
  always_comb begin
    op = rd;
    if (wb_we && (wb_wa == ra) && (ra != ZR_IDX)) op = wb_wd;
  end
endmodule

module idex_bypass_stage #(
  parameter int N  = 64,
  parameter int ZR = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [4:0]   id_ra1,
  input  logic [4:0]   id_ra2,
  input  logic [N-1:0] id_rd1,
  input  logic [N-1:0] id_rd2,
  input  logic [N-1:0] id_imm,
  input  logic [4:0]   id_wa,
  input  logic         id_regwrite,
  input  logic         id_memread,
  input  logic         wb_we,
  input  logic [4:0]   wb_wa,
  input  logic [N-1:0] wb_wd,
  output logic         ex_valid,
  output logic [N-1:0] ex_a,
  output logic [N-1:0] ex_b,
  output logic [N-1:0] ex_imm,
  output logic [4:0]   ex_wa,
  output logic         ex_regwrite,
  output logic         ex_memread,
  output logic         stall
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]  stall_count
`endif
);
  localparam int         NUM_OPS = 2;
  localparam logic [4:0] ZR_IDX  = 5'(ZR);

  logic [NUM_OPS-1:0][4:0]   ra_v;
  logic [NUM_OPS-1:0][N-1:0] rd_v;
  logic [NUM_OPS-1:0][N-1:0] op_v;

  logic         ex_valid_q, ex_valid_d;
  logic [N-1:0] ex_a_q, ex_a_d;
  logic [N-1:0] ex_b_q, ex_b_d;
  logic [N-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]   ex_wa_q, ex_wa_d;
  logic         ex_regwrite_q, ex_regwrite_d;
  logic         ex_memread_q, ex_memread_d;

  assign ra_v = {id_ra2, id_ra1};
  assign rd_v = {id_rd2, id_rd1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_byp
    idex_bypass_mux #(.N(N), .ZR(ZR)) u_byp (
      .ra    (ra_v[g]),
      .rd    (rd_v[g]),
      .wb_we (wb_we),
      .wb_wa (wb_wa),
      .wb_wd (wb_wd),
      .op    (op_v[g])
    );
  end

  // Load in EX feeding a source of the ID instruction: hold ID one cycle
  always_comb begin
    stall = id_valid && ex_valid_q && ex_memread_q && (ex_wa_q != ZR_IDX) &&
            ((ex_wa_q == id_ra1) || (ex_wa_q == id_ra2)) && !flush && !reset;
  end

  // Next EX contents: bubble on flush/stall (data held), else capture ID
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    ex_imm_d      = ex_imm_q;
    ex_wa_d       = ex_wa_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    if (flush || stall) begin
      ex_valid_d    = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
    end else begin
      ex_valid_d    = id_valid;
      ex_a_d        = op_v[0];
      ex_b_d        = op_v[1];
      ex_imm_d      = id_imm;
      ex_wa_d       = id_wa;
      ex_regwrite_d = id_regwrite && id_valid;
      ex_memread_d  = id_memread && id_valid;
    end
  end

  // ID/EX capture register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_imm_q      <= '0;
      ex_wa_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_imm_q      <= ex_imm_d;
      ex_wa_q       <= ex_wa_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_imm      = ex_imm_q;
  assign ex_wa       = ex_wa_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count load-use stall cycles; flush bubbles never raise stall
  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Stall counter register, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_idex_bypass_stage.sv
// Testbench for idex_bypass_stage: register-file model drives rd1/rd2 with
// the pre-write value; expected operands are the post-write architectural
// register values.
module tb_idex_bypass_stage;
  logic        clk, reset, flush, id_valid;
  logic [4:0]  id_ra1, id_ra2, id_wa, wb_wa;
  logic [63:0] id_rd1, id_rd2, id_imm, wb_wd;
  logic        id_regwrite, id_memread, wb_we;
  logic        ex_valid, ex_regwrite, ex_memread, stall;
  logic [63:0] ex_a, ex_b, ex_imm;
  logic [4:0]  ex_wa;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] exp_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        v;
    logic [63:0] a, b, imm;
    logic [4:0]  wa;
    logic        rw, mr;
  } ex_t;

  ex_t         m;
  logic [63:0] rf [32];

  assign id_rd1 = rf[id_ra1];
  assign id_rd2 = rf[id_ra2];

  idex_bypass_stage #(.N(64), .ZR(31)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_wa(id_wa), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_wa(ex_wa), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .stall(stall)
`ifdef IDEX_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_stall_f();
    return id_valid && m.v && m.mr && (m.wa != 5'd31) &&
           ((m.wa == id_ra1) || (m.wa == id_ra2)) && !flush && !reset;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] wa, input logic rw, input logic mr);
    id_valid = v; id_ra1 = r1; id_ra2 = r2; id_wa = wa;
    id_regwrite = rw; id_memread = mr; id_imm = {$urandom, $urandom};
  endtask

  task automatic set_wb(input logic we, input logic [4:0] wa, input logic [63:0] wd);
    wb_we = we; wb_wa = wa; wb_wd = wd;
  endtask

  // Advance one clock edge, updating the reference model from the
  // instruction-level rules (architectural register values after write-back).
  task automatic tick();
    ex_t         nx;
    logic        s;
    logic [63:0] rf_n [32];
    s = exp_stall_f();
    nx = m;
    rf_n = rf;
    if (wb_we && wb_wa != 5'd31) rf_n[wb_wa] = wb_wd;
    if (reset) nx = '0;
    else if (flush || s) begin
      nx.v = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0;
    end else begin
      nx.v = id_valid; nx.a = rf_n[id_ra1]; nx.b = rf_n[id_ra2];
      nx.imm = id_imm; nx.wa = id_wa;
      nx.rw = id_regwrite && id_valid; nx.mr = id_memread && id_valid;
    end
`ifdef IDEX_STALL_CNT_EN
    if (reset) exp_cnt = 32'd0;
    else if (s) exp_cnt = exp_cnt + 32'd1;
`endif
    @(posedge clk);
    m = nx;
    rf = rf_n;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'($urandom);
    set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
    set_wb(1'($urandom), 5'($urandom), {$urandom, $urandom});
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if ({ex_valid, ex_a, ex_b, ex_imm, ex_wa, ex_regwrite, ex_memread} !== '0) begin
      failures++;
      $display("FAIL reset_ex: got v=%b a=%h b=%h imm=%h wa=%0d rw=%b mr=%b expected all 0",
               ex_valid, ex_a, ex_b, ex_imm, ex_wa, ex_regwrite, ex_memread);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_after: got %b expected 0", stall); end
    reset = 1'b0; flush = 1'b0;
  endtask

  task automatic test_bypass();
    rf[3] = 64'd3; rf[5] = 64'd5;
    set_id(1'b1, 5'd3, 5'd5, 5'd2, 1'b1, 1'b0);
    set_wb(1'b0, 5'd0, 64'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL plain_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (ex_a !== 64'd3 || ex_b !== 64'd5 || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL plain_capture: got a=%h b=%h v=%b expected a=3 b=5 v=1", ex_a, ex_b, ex_valid);
    end
    checks++;
    if (ex_imm !== m.imm || ex_wa !== 5'd2 || ex_regwrite !== 1'b1 || ex_memread !== 1'b0) begin
      failures++;
      $display("FAIL plain_ctrl: got imm=%h wa=%0d rw=%b mr=%b expected imm=%h wa=2 rw=1 mr=0",
               ex_imm, ex_wa, ex_regwrite, ex_memread, m.imm);
    end
    set_wb(1'b1, 5'd5, 64'hDEAD);
    tick();
    checks++;
    if (ex_a !== 64'd3 || ex_b !== 64'hDEAD) begin
      failures++;
      $display("FAIL bypass_rd2: got a=%h b=%h expected a=3 b=dead", ex_a, ex_b);
    end
    set_id(1'b1, 5'd3, 5'd31, 5'd2, 1'b1, 1'b0);
    set_wb(1'b1, 5'd31, 64'h1234_5678_9ABC_DEF0);
    tick();
    checks++;
    if (ex_b !== 64'd0 || ex_a !== 64'd3) begin
      failures++;
      $display("FAIL bypass_xzr: got a=%h b=%h expected a=3 b=0", ex_a, ex_b);
    end
    set_wb(1'b1, 5'd3, 64'h77);
    tick();
    checks++;
    if (ex_a !== 64'h77) begin failures++; $display("FAIL bypass_rd1: got %h expected 77", ex_a); end
    set_wb(1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd0, 5'd1, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 5'd9, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %b expected 1", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL lu_bubble: got v=%b mr=%b rw=%b expected 0 0 0", ex_valid, ex_memread, ex_regwrite);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_drop: got %b expected 0", stall); end
    set_wb(1'b1, 5'd7, 64'hCAFE_0007);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_a !== 64'hCAFE_0007 || ex_wa !== 5'd9 || ex_b !== m.b) begin
      failures++;
      $display("FAIL lu_capture: got v=%b a=%h b=%h wa=%0d expected v=1 a=cafe0007 b=%h wa=9",
               ex_valid, ex_a, ex_b, ex_wa, m.b);
    end
    set_wb(1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd0, 5'd1, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd7, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_memread !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble: got v=%b mr=%b expected 0 0", ex_valid, ex_memread);
    end
    flush = 1'b0;
    set_id(1'b1, 5'd0, 5'd1, 5'd31, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd31, 5'd31, 5'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL xzr_load_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_a !== 64'd0) begin
      failures++;
      $display("FAIL xzr_load_capture: got v=%b a=%h expected v=1 a=0", ex_valid, ex_a);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom % 9; id_ra1 = (r == 8) ? 5'd31 : 5'(r);
      r = $urandom % 9; id_ra2 = (r == 8) ? 5'd31 : 5'(r);
      r = $urandom % 9; id_wa  = (r == 8) ? 5'd31 : 5'(r);
      r = $urandom % 9; wb_wa  = (r == 8) ? 5'd31 : 5'(r);
      id_valid = ($urandom % 4) != 0;
      id_regwrite = 1'($urandom); id_memread = ($urandom % 3) == 0;
      id_imm = {$urandom, $urandom};
      wb_we = 1'($urandom); wb_wd = {$urandom, $urandom};
      flush = ($urandom % 8) == 0;
      reset = ($urandom % 40) == 0;
      #1;
      checks++;
      if (stall !== exp_stall_f()) begin
        failures++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, stall, exp_stall_f());
      end
      tick();
      checks++;
      if (ex_valid !== m.v || ex_regwrite !== m.rw || ex_memread !== m.mr) begin
        failures++;
        $display("FAIL rnd_ctrl[%0d]: got v=%b rw=%b mr=%b expected v=%b rw=%b mr=%b",
                 i, ex_valid, ex_regwrite, ex_memread, m.v, m.rw, m.mr);
      end
      if (m.v) begin
        checks++;
        if (ex_a !== m.a || ex_b !== m.b || ex_imm !== m.imm || ex_wa !== m.wa) begin
          failures++;
          $display("FAIL rnd_data[%0d]: got a=%h b=%h imm=%h wa=%0d expected a=%h b=%h imm=%h wa=%0d",
                   i, ex_a, ex_b, ex_imm, ex_wa, m.a, m.b, m.imm, m.wa);
        end
      end
`ifdef IDEX_STALL_CNT_EN
      checks++;
      if (stall_count !== exp_cnt) begin
        failures++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, stall_count, exp_cnt);
      end
`endif
    end
    reset = 1'b0; flush = 1'b0;
    set_wb(1'b0, 5'd0, 64'd0);
  endtask

`ifdef IDEX_STALL_CNT_EN
  task automatic load_use_pair();
    set_id(1'b1, 5'd0, 5'd1, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 5'd9, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_stall_count();
    reset = 1'b1; tick(); reset = 1'b0;
    set_wb(1'b0, 5'd0, 64'd0);
    for (int k = 0; k < 3; k++) load_use_pair();
    checks++;
    if (stall_count !== 32'd3) begin failures++; $display("FAIL cnt_three: got %0d expected 3", stall_count); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (stall_count !== 32'd0) begin failures++; $display("FAIL cnt_reset: got %0d expected 0", stall_count); end
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    load_use_pair();
    checks++;
    if (stall_count !== 32'd0) begin failures++; $display("FAIL cnt_wrap: got %h expected 0", stall_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 31) ? 64'd0 : {$urandom, $urandom};
    m = '0;
`ifdef IDEX_STALL_CNT_EN
    exp_cnt = 32'd0;
`endif
    reset = 1'b1; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 64'd0);
    test_reset();
    test_bypass();
    test_load_use();
    test_flush();
    test_random();
`ifdef IDEX_STALL_CNT_EN
    test_stall_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
